div_unit: RTL and testbench

//  Multi-cycle 32/32 radix-2 restoring divider for DIV/DIVU in the EX stage.

---
 rtl/div_unit_pkg.sv | 23 ++
 rtl/div_unit_step.sv | 27 ++
 rtl/div_unit.sv | 147 ++++++++++++++
 tb/tb_div_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle restoring divider: state encodings,
// request/ready levels and bus widths.
package div_unit_pkg;

    localparam int DIV_DATA_W       = 32;
    localparam int DOUBLE_REG_BUS_W = 2 * DIV_DATA_W;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [DIV_DATA_W-1:0]       ZERO_WORD   = '0;
    localparam logic [DOUBLE_REG_BUS_W-1:0] ZERO_DOUBLE = '0;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the
// divisor from the upper DATA_W+1 bits, keep or restore, shift in the quotient bit.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] work,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W-1:0] work_next
);

    logic [DATA_W:0]   upper;
    logic [DATA_W:0]   diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_new;

    // upper is bits [64:32] of the 65-bit shifted value {0, rem, quo, 0}.
    // A restored remainder never exceeds the divisor, so its top bit is always 0
    // and the result fits back into DATA_W bits.
    always_comb begin
        upper     = work[2*DATA_W-1:DATA_W-1];
        diff      = upper - {1'b0, divisor};
        q_bit     = ~diff[DATA_W];
        rem_new   = q_bit ? diff[DATA_W-1:0] : upper[DATA_W-1:0];
        work_next = {rem_new, work[DATA_W-2:0], q_bit};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32/32 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Operands are latched as magnitudes in FREE and the signs are fixed after the last step.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W);

    div_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [2*DATA_W-1:0] work_reg, work_next, step_out;
    logic [DATA_W-1:0]   divisor_reg, divisor_next;
    logic                sign1_reg, sign1_next;
    logic                sign2_reg, sign2_next;
    logic                signed_reg, signed_next;
    logic [2*DATA_W-1:0] result_next;
    logic                ready_next;

    logic              op1_neg, op2_neg;
    logic [DATA_W-1:0] op1_mag, op2_mag;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_mag = op1_neg ? (ZERO_WORD - opdata1_i) : opdata1_i;
        op2_mag = op2_neg ? (ZERO_WORD - opdata2_i) : opdata2_i;
    end

    // Quotient sign is the XOR of the operand signs; remainder follows the dividend.
    always_comb begin
        quo_fix = (signed_reg && (sign1_reg ^ sign2_reg))
                  ? (ZERO_WORD - work_reg[DATA_W-1:0]) : work_reg[DATA_W-1:0];
        rem_fix = (signed_reg && sign1_reg)
                  ? (ZERO_WORD - work_reg[2*DATA_W-1:DATA_W]) : work_reg[2*DATA_W-1:DATA_W];
    end

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .work      (work_reg),
        .divisor   (divisor_reg),
        .work_next (step_out)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        sign1_next   = sign1_reg;
        sign2_next   = sign2_reg;
        signed_next  = signed_reg;
        result_next  = ZERO_DOUBLE;
        ready_next   = DIV_RESULT_NOT_READY;

        unique case (state_reg)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    sign1_next  = opdata1_i[DATA_W-1];
                    sign2_next  = opdata2_i[DATA_W-1];
                    signed_next = signed_div_i;
                    if (opdata2_i == ZERO_WORD) begin
                        state_next = DIV_BY_ZERO;
                    end else begin
                        state_next   = DIV_ON;
                        cnt_next     = '0;
                        work_next    = {ZERO_WORD, op1_mag};
                        divisor_next = op2_mag;
                    end
                end
            end

            DIV_BY_ZERO: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_next = DIV_FREE;
                end else begin
                    work_next  = ZERO_DOUBLE;
                    state_next = DIV_END;
                end
            end

            DIV_ON: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_next = DIV_FREE;
                end else if (cnt_reg != LAST_CNT) begin
                    work_next = step_out;
                    cnt_next  = cnt_reg + 1'b1;
                end else begin
                    work_next  = {rem_fix, quo_fix};
                    cnt_next   = '0;
                    state_next = DIV_END;
                end
            end

            DIV_END: begin
                // annul_i is deliberately not looked at here: EX drops start_i on a flush.
                if (start_i == DIV_START) begin
                    result_next = work_reg;
                    ready_next  = DIV_RESULT_READY;
                end else begin
                    state_next = DIV_FREE;
                end
            end

            default: state_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= DIV_FREE;
            cnt_reg     <= '0;
            work_reg    <= ZERO_DOUBLE;
            divisor_reg <= ZERO_WORD;
            sign1_reg   <= 1'b0;
            sign2_reg   <= 1'b0;
            signed_reg  <= 1'b0;
            result_o    <= ZERO_DOUBLE;
            ready_o     <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            sign1_reg   <= sign1_next;
            sign2_reg   <= sign2_next;
            signed_reg  <= signed_next;
            result_o    <= result_next;
            ready_o     <= ready_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a cycle-level expectation of ready_o/result_o driven by
// latency rules and an arithmetic reference divider, checked every cycle.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    logic        exp_ready;
    logic [63:0] exp_result;
    bit          chk_en;
    int          errors;
    int          checks;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference divide with plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic set_idle_exp();
        exp_ready  = 1'b0;
        exp_result = 64'd0;
    endtask

    // Called at posedge+1 with the DUT idle. Ready must appear 34 posedges after the
    // sampling posedge (2 for a zero divisor); operands are scrambled once accepted.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expv, input int hold, input bit keep);
        int lat;
        lat = (b == 32'd0) ? 2 : 34;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            exp_ready  = (k == lat);
            exp_result = (k == lat) ? expv : 64'd0;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        $display("txn sgn=%0d a=%h b=%h expect=%h got=%h", sgn, a, b, expv, result_o);
        if (!keep) begin
            start_i = 1'b0;
            @(posedge clk); #1;
            set_idle_exp();
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bit          sgn;
        int          sel;

        errors       = 0;
        checks       = 0;
        chk_en       = 1'b0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        set_idle_exp();

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    checks++;
                    if (ready_o !== exp_ready || result_o !== exp_result) begin
                        errors++;
                        $display("FAIL cycle_cmp t=%0t ready=%0b result=%h expected ready=%0b result=%h",
                                 $time, ready_o, result_o, exp_ready, exp_result);
                    end
                end
            end
        join_none

        // Pin the reference model itself with hand-worked values.
        chk64("model_divu_100_7",  ref_div(1'b0, 32'd100, 32'd7),               64'h00000002_0000000E);
        chk64("model_div_m7_2",    ref_div(1'b1, 32'hFFFFFFF9, 32'd2),          64'hFFFFFFFF_FFFFFFFD);
        chk64("model_div_7_m2",    ref_div(1'b1, 32'd7, 32'hFFFFFFFE),          64'h00000001_FFFFFFFD);
        chk64("model_div_ovf",     ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF),   64'h00000000_80000000);
        chk64("model_divu_big",    ref_div(1'b0, 32'hFFFFFFF9, 32'd2),          64'h00000001_7FFFFFFC);
        chk64("model_small_big",   ref_div(1'b0, 32'd5, 32'd9),                 64'h00000005_00000000);
        chk64("model_by_zero",     ref_div(1'b1, 32'h12345678, 32'd0),          64'd0);

        #2 rst = 1'b0;
        #2;
        chk64("reset_result", result_o, 64'd0);
        chk64("reset_ready", {63'd0, ready_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;

        // Directed cases with literal expectations.
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 2, 1'b0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0, 1'b0);
        run_div(1'b1, 32'h12345678, 32'd0, 64'd0, 1, 1'b0);
        run_div(1'b0, 32'hDEADBEEF, 32'd0, 64'd0, 0, 1'b0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1, 1'b0);
        run_div(1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 0, 1'b0);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0, 1'b0);

        // Flush at iteration 10 with start still held: must stay idle until annul drops.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        annul_i = 1'b0;
        run_div(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 0, 1'b0);

        // Dropping start mid-divide discards it; a new request restarts from scratch.
        signed_div_i = 1'b1; opdata1_i = 32'hFFFF0000; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        start_i = 1'b0;
        @(posedge clk); #1;
        run_div(1'b0, 32'd77, 32'd10, 64'h00000007_00000007, 0, 1'b0);

        // Asynchronous reset in the middle of a divide, away from the clock edge.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        #2;
        chk_en = 1'b0; rst = 1'b0; start_i = 1'b0;
        #1;
        chk64("rst_mid_on_result", result_o, 64'd0);
        chk64("rst_mid_on_ready", {63'd0, ready_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; chk_en = 1'b1;
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 0, 1'b0);

        // Asynchronous reset while a result is being presented.
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1, 1'b1);
        #2;
        chk_en = 1'b0; rst = 1'b0; start_i = 1'b0;
        #1;
        chk64("rst_in_end_result", result_o, 64'd0);
        chk64("rst_in_end_ready", {63'd0, ready_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; set_idle_exp(); chk_en = 1'b1;

        // Random sweep against the reference divider, both signed modes.
        for (int n = 0; n < 500; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = a + $urandom_range(1, 100);
                4: a = $urandom_range(0, 1000);
                default: ;
            endcase
            run_div(sgn, a, b, ref_div(sgn, a, b), $urandom_range(0, 2), 1'b0);
        end

        repeat (3) begin @(posedge clk); #1; end
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
